// File: rtl/md_scheduler_pkg.sv
// Shared HI/LO opcode encodings for the decoder and the mult/div scheduler.
package md_scheduler_pkg;

   localparam int unsigned HiLoOpW = 4;
   localparam int unsigned CntW    = 4;

   localparam logic [HiLoOpW-1:0] NOP_FOR_HI_LO = 4'd0;
   localparam logic [HiLoOpW-1:0] MULT_OP       = 4'd1;
   localparam logic [HiLoOpW-1:0] MULTU_OP      = 4'd2;
   localparam logic [HiLoOpW-1:0] DIV_OP        = 4'd3;
   localparam logic [HiLoOpW-1:0] DIVU_OP       = 4'd4;
   localparam logic [HiLoOpW-1:0] MFHI_OP       = 4'd5;
   localparam logic [HiLoOpW-1:0] MFLO_OP       = 4'd6;
   localparam logic [HiLoOpW-1:0] MTHI_OP       = 4'd7;
   localparam logic [HiLoOpW-1:0] MTLO_OP       = 4'd8;

   // True for the multi-cycle opcodes that occupy the busy counter.
   function automatic logic is_muldiv(input logic [HiLoOpW-1:0] op);
      return (op == MULT_OP) || (op == MULTU_OP) || (op == DIV_OP) || (op == DIVU_OP);
   endfunction

   // True for the multiply opcodes (as opposed to divides).
   function automatic logic is_mult(input logic [HiLoOpW-1:0] op);
      return (op == MULT_OP) || (op == MULTU_OP);
   endfunction

endpackage

// File: rtl/md_scheduler.sv
// E-stage multiply/divide scheduler: owns HI/LO, times mult/div with a busy
// counter and asks the hazard unit to hold HI/LO instructions in D.
module md_scheduler
   import md_scheduler_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         HiLoOp,
   input  logic [31:0]        A,
   input  logic [31:0]        B,
   input  logic               D_isHiLo,
   output logic               Start,
   output logic               Busy,
   output logic               Stall,
   output logic [31:0]        HiLoOut
);

   localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
   localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

   logic [31:0]     hi_q, hi_d, lo_q, lo_d;
   logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic            pend_valid_q, pend_valid_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [63:0]     prod_s, prod_u;
   logic [31:0]     div_b, quot_s, rem_s, quot_u, rem_u;
   logic            b_zero;

   assign Busy  = (cnt_q != '0);
   assign Start = ~Busy & is_muldiv(HiLoOp);
   assign Stall = D_isHiLo & (Start | Busy);

   // Behavioural arithmetic; a zero divisor is replaced by 1 so the datapath
   // never produces X, and the result is discarded via pend_valid anyway.
   assign b_zero = (B == 32'd0);
   assign div_b  = b_zero ? 32'd1 : B;
   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};
   assign quot_s = $signed(A) / $signed(div_b);
   assign rem_s  = $signed(A) % $signed(div_b);
   assign quot_u = A / div_b;
   assign rem_u  = A % div_b;

   // Next-state for counter, pending result and HI/LO; ops seen while Busy are dropped.
   always_comb begin
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      pend_valid_d = pend_valid_q;
      if (Busy) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CntW'(1) && pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (Start) begin
         cnt_d        = is_mult(HiLoOp) ? MultCnt : DivCnt;
         pend_valid_d = is_mult(HiLoOp) | ~b_zero;
         case (HiLoOp)
            MULT_OP:  {pend_hi_d, pend_lo_d} = prod_s;
            MULTU_OP: {pend_hi_d, pend_lo_d} = prod_u;
            DIV_OP:   {pend_hi_d, pend_lo_d} = {rem_s, quot_s};
            default:  {pend_hi_d, pend_lo_d} = {rem_u, quot_u};
         endcase
      end else if (HiLoOp == MTHI_OP) begin
         hi_d = A;
      end else if (HiLoOp == MTLO_OP) begin
         lo_d = A;
      end
   end

   // State register: counter, pending result and HI/LO together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         pend_hi_q    <= '0;
         pend_lo_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         pend_hi_q    <= pend_hi_d;
         pend_lo_q    <= pend_lo_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // Read port for mfhi/mflo.
   always_comb begin
      HiLoOut = 32'd0;
      case (HiLoOp)
         MFHI_OP: HiLoOut = hi_q;
         MFLO_OP: HiLoOut = lo_q;
         default: HiLoOut = 32'd0;
      endcase
   end

endmodule
